// File: rtl/vga_fetch_pkg.sv
// Shared definitions for the VGA scanline fetch sequencer: FSM state
// encoding, mode geometry, control-register bit positions, pixel packing
// and the burst address helper.
package vga_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetchState_t;

  localparam logic [11:0] VGA_W_LO = 12'd640;
  localparam logic [11:0] VGA_H_LO = 12'd480;
  localparam logic [11:0] VGA_W_HI = 12'd800;
  localparam logic [11:0] VGA_H_HI = 12'd600;

  localparam int unsigned CTRL_MODE800  = 3;
  localparam int unsigned CTRL_DBLSCAN  = 4;
  localparam int unsigned CTRL_FETCH_EN = 8;

  // Packed pixel layout inside a 32-bit memory half-word: {Cy,Cu,Cv,aux8}
  localparam int unsigned PIX_CY_LSB  = 24;
  localparam int unsigned PIX_CU_LSB  = 16;
  localparam int unsigned PIX_CV_LSB  = 8;
  localparam int unsigned PIX_AUX_LSB = 0;
  localparam logic [31:0] PIX_BLACK   = 32'h0080_8000;

  // One line fetch, captured at trigger time so later mode changes do not
  // disturb a fetch already under way.
  typedef struct packed {
    logic [11:0] src;
    logic        half;
    logic [11:0] lw;
  } fetchJob_t;

  function automatic logic [31:0] burstAddr(input logic [31:0] base,
                                            input logic [15:0] stride,
                                            input logic [11:0] line,
                                            input logic [11:0] word);
    return base + 32'(line) * 32'(stride) + {17'd0, word, 3'b000};
  endfunction

endpackage

// File: rtl/vga_line_ram.sv
// Ping-pong line buffer: 2 x BUF_WORDS x 64-bit simple dual-port RAM.
// Ports: clock; wrEn/wrAddr/wrData write port; rdAddr/rdData synchronous
// read port (one clock latency). Address MSB selects the buffer half.
module vga_line_ram #(
  parameter  int unsigned BUF_WORDS = 512,
  localparam int unsigned AW        = $clog2(BUF_WORDS)
) (
  input  logic          clock,
  input  logic          wrEn,
  input  logic [AW:0]   wrAddr,
  input  logic [63:0]   wrData,
  input  logic [AW:0]   rdAddr,
  output logic [63:0]   rdData
);

  logic [63:0] mem [2**(AW+1)];

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/vga_line_fetch.sv
// Scanline fetch sequencer between the memory port and the VGA timing stage.
// On every change of pixPosY it prefetches a framebuffer line into one half
// of a ping-pong line buffer, one burst at a time, and serves the current
// pixel from the buffer with two clocks of latency.
// Ports: clock/reset (async, active high); ctrlRegVal/fbBase/fbStride
// configuration; pixPosX/pixPosY display position; pixCy/pixCu/pixCv/pixAux
// pixel out; memReq*/memRsp* burst read port; statClear, statUnderrun,
// statLate sticky status.
// Optional: define VGA_LINEFETCH_DBLSCAN_EN to enable double-scan via
// ctrlRegVal[4].
module vga_line_fetch
  import vga_fetch_pkg::*;
#(
  parameter int unsigned BURST_WORDS = 8,
  parameter int unsigned BUF_WORDS   = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] ctrlRegVal,
  input  logic [31:0] fbBase,
  input  logic [15:0] fbStride,
  input  logic [11:0] pixPosX,
  input  logic [11:0] pixPosY,
  output logic [7:0]  pixCy,
  output logic [7:0]  pixCu,
  output logic [7:0]  pixCv,
  output logic [15:0] pixAux,
  output logic        memReqValid,
  output logic [31:0] memReqAddr,
  input  logic        memReqReady,
  input  logic        memRspValid,
  input  logic [63:0] memRspData,
  input  logic        memRspLast,
  input  logic        statClear,
  output logic        statUnderrun,
  output logic        statLate
);

  localparam int unsigned AW = $clog2(BUF_WORDS);

  if (BURST_WORDS == 0 || (BURST_WORDS & (BURST_WORDS - 1)) != 0) begin : gBurstChk
    $error("BURST_WORDS must be a power of two");
  end
  if (BUF_WORDS < 400) begin : gBufChk
    $error("BUF_WORDS must be at least 400");
  end

  fetchState_t state;
  fetchJob_t   curJob, pendJob, newJob, startJob;
  logic        latePend;
  logic [11:0] wordCnt;
  logic [11:0] posYReg;
  logic [1:0]  lineValid;

  logic [11:0] modeW, modeH, target;
  logic        fetchEn, trigger, lateSet;

  logic          dispHalf, dispSel, inRange, showBlack, underrunSet;
  logic [AW-1:0] dispWord;
  logic          ramWrEn;
  logic [63:0]   rdData;
  logic          blackD, selD;
  logic [31:0]   pixVal;

  logic unusedCtrl;
  assign unusedCtrl = ^{ctrlRegVal[63:9], ctrlRegVal[7:4], ctrlRegVal[2:0]};

  // The target is derived from the previous (registered) Y, so the step
  // from the 0xFFF reset/blanking value to any row fetches line 0.
  always_comb begin
    modeW   = ctrlRegVal[CTRL_MODE800] ? VGA_W_HI : VGA_W_LO;
    modeH   = ctrlRegVal[CTRL_MODE800] ? VGA_H_HI : VGA_H_LO;
    fetchEn = ctrlRegVal[CTRL_FETCH_EN];
    target  = posYReg + 12'd1;
    newJob.src  = target;
    newJob.half = target[0];
    newJob.lw   = modeW >> 1;
    trigger = (pixPosY != posYReg) && fetchEn && (target < modeH);
`ifdef VGA_LINEFETCH_DBLSCAN_EN
    if (ctrlRegVal[CTRL_DBLSCAN]) begin
      newJob.src  = target >> 1;
      newJob.half = target[1];
      newJob.lw   = modeW >> 2;
      trigger     = trigger && !target[0];
    end
`endif
    startJob = trigger ? newJob : pendJob;
    lateSet  = trigger && (state == ST_REQ || state == ST_WAIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) posYReg <= 12'hFFF;
    else       posYReg <= pixPosY;
  end

  // A trigger outside IDLE is parked in pendJob; the newest one wins and is
  // started from IDLE once the current burst or DONE step has finished.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      curJob      <= '0;
      pendJob     <= '0;
      latePend    <= 1'b0;
      wordCnt     <= '0;
      lineValid   <= '0;
      memReqValid <= 1'b0;
      memReqAddr  <= '0;
      statLate    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger || latePend) begin
            curJob                   <= startJob;
            lineValid[startJob.half] <= 1'b0;
            wordCnt                  <= '0;
            latePend                 <= 1'b0;
            memReqValid              <= 1'b1;
            memReqAddr               <= burstAddr(fbBase, fbStride, startJob.src, 12'd0);
            state                    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (memReqReady) begin
            memReqValid <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (memRspValid) begin
            wordCnt <= wordCnt + 12'd1;
            if (memRspLast) begin
              if (latePend) begin
                state <= ST_IDLE;
              end else if (wordCnt + 12'd1 >= curJob.lw) begin
                state <= ST_DONE;
              end else begin
                memReqValid <= 1'b1;
                memReqAddr  <= burstAddr(fbBase, fbStride, curJob.src, wordCnt + 12'd1);
                state       <= ST_REQ;
              end
            end
          end
        end
        ST_DONE: begin
          lineValid[curJob.half] <= 1'b1;
          state                  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (trigger && state != ST_IDLE) begin
        latePend <= 1'b1;
        pendJob  <= newJob;
      end

      if (lateSet)        statLate <= 1'b1;
      else if (statClear) statLate <= 1'b0;
    end
  end

  assign ramWrEn = (state == ST_WAIT) && memRspValid && (wordCnt < curJob.lw);

  always_comb begin
    dispHalf = pixPosY[0];
    dispWord = pixPosX[AW:1];
    dispSel  = pixPosX[0];
`ifdef VGA_LINEFETCH_DBLSCAN_EN
    if (ctrlRegVal[CTRL_DBLSCAN]) begin
      dispHalf = pixPosY[1];
      dispWord = pixPosX[AW+1:2];
      dispSel  = pixPosX[1];
    end
`endif
    inRange     = (pixPosX < modeW) && (pixPosY < modeH);
    showBlack   = !inRange || !lineValid[dispHalf] || !fetchEn;
    underrunSet = inRange && fetchEn && !lineValid[dispHalf];
  end

  vga_line_ram #(.BUF_WORDS(BUF_WORDS)) uLineRam (
    .clock  (clock),
    .wrEn   (ramWrEn),
    .wrAddr ({curJob.half, wordCnt[AW-1:0]}),
    .wrData (memRspData),
    .rdAddr ({dispHalf, dispWord}),
    .rdData (rdData)
  );

  always_comb begin
    pixVal = selD ? rdData[63:32] : rdData[31:0];
    if (blackD) pixVal = PIX_BLACK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blackD       <= 1'b1;
      selD         <= 1'b0;
      pixCy        <= PIX_BLACK[PIX_CY_LSB +: 8];
      pixCu        <= PIX_BLACK[PIX_CU_LSB +: 8];
      pixCv        <= PIX_BLACK[PIX_CV_LSB +: 8];
      pixAux       <= '0;
      statUnderrun <= 1'b0;
    end else begin
      blackD <= showBlack;
      selD   <= dispSel;
      pixCy  <= pixVal[PIX_CY_LSB +: 8];
      pixCu  <= pixVal[PIX_CU_LSB +: 8];
      pixCv  <= pixVal[PIX_CV_LSB +: 8];
      pixAux <= {8'h00, pixVal[PIX_AUX_LSB +: 8]};
      if (underrunSet)    statUnderrun <= 1'b1;
      else if (statClear) statUnderrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a simple burst memory responder.
// Memory word at byte address a holds {a, ~a}, except the first word of
// the 0x10000 framebuffer which holds 0x11223344_55667788.
module tb_vga_line_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] ctrlRegVal;
  logic [31:0] fbBase;
  logic [15:0] fbStride;
  logic [11:0] pixPosX, pixPosY;
  logic [7:0]  pixCy, pixCu, pixCv;
  logic [15:0] pixAux;
  logic        memReqValid, memReqReady, memRspValid, memRspLast;
  logic [31:0] memReqAddr;
  logic [63:0] memRspData;
  logic        statClear, statUnderrun, statLate;

  int unsigned nCompared = 0;
  int unsigned nMismatch = 0;

  // responder controls and log
  int unsigned stallNext = 0, delayNext = 0, stallBad = 0;
  int unsigned extraLast = 0;
  logic [31:0] extraBase = '0;
  int unsigned extraLw = 0;
  int unsigned reqCount = 0;
  logic [31:0] reqLog [256];

  localparam logic [39:0] BLACK = 40'h00_80_80_0000;
  logic [39:0] pixAll;
  assign pixAll = {pixCy, pixCu, pixCv, pixAux};

  always #5 clock = ~clock;

  vga_line_fetch #(.BURST_WORDS(8), .BUF_WORDS(512)) dut (
    .clock(clock), .reset(reset), .ctrlRegVal(ctrlRegVal), .fbBase(fbBase),
    .fbStride(fbStride), .pixPosX(pixPosX), .pixPosY(pixPosY),
    .pixCy(pixCy), .pixCu(pixCu), .pixCv(pixCv), .pixAux(pixAux),
    .memReqValid(memReqValid), .memReqAddr(memReqAddr), .memReqReady(memReqReady),
    .memRspValid(memRspValid), .memRspData(memRspData), .memRspLast(memRspLast),
    .statClear(statClear), .statUnderrun(statUnderrun), .statLate(statLate)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic waitReq(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned c = 0;
    while (reqCount < target && c < budget) begin
      tick(1);
      c++;
    end
    checkVal(tag, 64'(reqCount), 64'(target));
  endtask

  function automatic logic [63:0] memWord(input logic [31:0] a);
    if (a == 32'h0001_0000) return 64'h11223344_55667788;
    return {a, ~a};
  endfunction

  initial begin : responder
    logic [31:0] reqAddr;
    int unsigned len, stall, dly;
    memReqReady = 1'b0; memRspValid = 1'b0; memRspLast = 1'b0; memRspData = '0;
    forever begin
      @(posedge clock); #1;
      if (memReqValid === 1'b1) begin
        reqAddr = memReqAddr;
        stall = stallNext; stallNext = 0;
        dly = delayNext; delayNext = 0;
        for (int i = 0; i < int'(stall); i++) begin
          @(posedge clock); #1;
          if (memReqValid !== 1'b1 || memReqAddr !== reqAddr) stallBad++;
        end
        memReqReady = 1'b1;
        @(posedge clock); #1;
        memReqReady = 1'b0;
        reqLog[reqCount[7:0]] = reqAddr;
        reqCount++;
        repeat (dly) @(posedge clock);
        if (dly > 0) #1;
        len = 8;
        if (extraLast > 0 && ((reqAddr - extraBase) >> 3) + 8 >= extraLw) len = 8 + extraLast;
        for (int w = 0; w < int'(len); w++) begin
          memRspValid = 1'b1;
          memRspData  = memWord(reqAddr + 32'(w * 8));
          memRspLast  = (w == int'(len) - 1);
          @(posedge clock); #1;
        end
        memRspValid = 1'b0; memRspLast = 1'b0;
      end
    end
  end

  initial begin : mainSeq
    int unsigned bad;
    reset = 1'b1; ctrlRegVal = 64'h100; fbBase = 32'h0001_0000; fbStride = 16'd1280;
    pixPosX = 12'h7FF; pixPosY = 12'hFFF; statClear = 1'b0;
    tick(3);
    checkVal("rstPix", 64'(pixAll), 64'(BLACK));
    checkVal("rstReqValid", 64'(memReqValid), 64'd0);
    checkVal("rstReqAddr", 64'(memReqAddr), 64'd0);
    checkVal("rstFlags", 64'({statUnderrun, statLate}), 64'd0);
    reset = 1'b0;
    tick(2);

    // line 0 in 640x480, first request stalled 20 cycles
    stallNext = 20;
    pixPosY = 12'd0;
    waitReq("line0Reqs", 40, 2000);
    tick(15);
    checkVal("stallHold", 64'(stallBad), 64'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) if (reqLog[i] !== 32'h10000 + 32'(i * 64)) bad++;
    checkVal("line0Addrs", 64'(bad), 64'd0);
    checkVal("line0LastAddr", 64'(reqLog[39]), 64'h109C0);
    pixPosX = 12'd0; tick(2);
    checkVal("pixX0", 64'(pixAll), 64'h55_66_77_0088);
    pixPosX = 12'd1; tick(2);
    checkVal("pixX1", 64'(pixAll), 64'h11_22_33_0044);
    pixPosX = 12'd2; tick(2);
    checkVal("pixX2", 64'(pixAll), 64'hFF_FE_FF_00F7);
    pixPosX = 12'd639; tick(2);
    checkVal("pixX639", 64'(pixAll), 64'h00_01_09_00F8);
    pixPosX = 12'd640; tick(2);
    checkVal("pixX640", 64'(pixAll), 64'(BLACK));
    checkVal("line0Flags", 64'({statUnderrun, statLate}), 64'd0);

    // late trigger while fetching line 5
    pixPosX = 12'h7FF; ctrlRegVal = 64'h0; pixPosY = 12'd4; tick(2);
    ctrlRegVal = 64'h100; delayNext = 8; pixPosY = 12'd5;
    waitReq("line5Req", 41, 200);
    checkVal("line5Addr", 64'(reqLog[40]), 64'h11900);
    pixPosY = 12'd6; tick(1);
    checkVal("lateSet", 64'(statLate), 64'd1);
    waitReq("line6FirstReq", 42, 200);
    checkVal("line6Addr", 64'(reqLog[41]), 64'h11E00);
    waitReq("line6Reqs", 81, 2000);
    tick(15);
    pixPosY = 12'd5; pixPosX = 12'd0; tick(2);
    checkVal("abortedBlack", 64'(pixAll), 64'(BLACK));
    checkVal("underrunSet", 64'(statUnderrun), 64'd1);
    pixPosX = 12'h7FF; tick(1);
    statClear = 1'b1; tick(1); statClear = 1'b0;
    checkVal("flagsCleared", 64'({statUnderrun, statLate}), 64'd0);
    waitReq("line7Reqs", 121, 2000);
    tick(15);

    // 800x600: line 6 with two surplus words in the last burst
    ctrlRegVal = 64'h108; extraLast = 2; extraBase = 32'h11E00; extraLw = 400;
    pixPosY = 12'd6;
    waitReq("wideReqs", 171, 2500);
    tick(20);
    checkVal("wideLastAddr", 64'(reqLog[170]), 64'h12A40);
    checkVal("wideNoExtraReq", 64'(reqCount), 64'd171);
    extraLast = 0;
    pixPosX = 12'd799; tick(2);
    checkVal("pixX799", 64'(pixAll), 64'h00_01_2A_0078);
    pixPosX = 12'd800; tick(2);
    checkVal("pixX800", 64'(pixAll), 64'(BLACK));

    // reset in the middle of a burst for line 7 (half 1) while showing line 6
    pixPosX = 12'd0; delayNext = 4; pixPosY = 12'd8;
    waitReq("rstLineReq", 172, 200);
    checkVal("rstLineAddr", 64'(reqLog[171]), 64'h12300);
    tick(6);
    checkVal("preRstPix", 64'(pixAll), 64'hFF_FE_E1_00FF);
    reset = 1'b1; pixPosY = 12'hFFF; #1;
    checkVal("rstPixNow", 64'(pixAll), 64'(BLACK));
    checkVal("rstReqNow", 64'(memReqValid), 64'd0);
    tick(3);
    reset = 1'b0;
    tick(15);
    checkVal("postRstNoReq", 64'({reqCount[15:0], 15'd0, memReqValid}), 64'({16'd172, 16'd0}));
    checkVal("postRstLate", 64'(statLate), 64'd0);
    pixPosY = 12'd1; tick(2);
    checkVal("postRstHalf1Black", 64'(pixAll), 64'(BLACK));
    checkVal("postRstUnderrun", 64'(statUnderrun), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
